// File: rtl/chart_pkg.sv
// -----------------------------------------------------------------------------
// chart_pkg
// Shared definitions for the note-chart sequencer: chart entry field widths,
// the end-of-chart delay marker, lane note codes, the sequencer state type and
// a helper that recognises the defined note codes.
// -----------------------------------------------------------------------------
package chart_pkg;

    localparam int unsigned CODE_W    = 4;
    localparam int unsigned DELAY_W   = 10;
    localparam int unsigned ENTRY_W   = CODE_W + DELAY_W;
    localparam int unsigned END_DELAY = 1000;

    // Lane note codes carried in the upper field of each chart entry.
    localparam logic [CODE_W-1:0] NOTE_NONE = 4'd0;
    localparam logic [CODE_W-1:0] NOTE_R    = 4'd1;
    localparam logic [CODE_W-1:0] NOTE_G    = 4'd2;
    localparam logic [CODE_W-1:0] NOTE_B    = 4'd3;
    localparam logic [CODE_W-1:0] NOTE_Y    = 4'd4;
    localparam logic [CODE_W-1:0] NOTE_RG   = 4'd5;
    localparam logic [CODE_W-1:0] NOTE_BY   = 4'd6;
    localparam logic [CODE_W-1:0] NOTE_RG2  = 4'd7;
    localparam logic [CODE_W-1:0] NOTE_YB2  = 4'd8;
    localparam logic [CODE_W-1:0] NOTE_ALT0 = 4'd11;
    localparam logic [CODE_W-1:0] NOTE_ALT1 = 4'd12;
    localparam logic [CODE_W-1:0] NOTE_ALT2 = 4'd13;
    localparam logic [CODE_W-1:0] NOTE_ALT3 = 4'd14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EMIT  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // True for codes that map to a lane (NOTE_NONE counts as defined).
    function automatic logic code_is_defined(input logic [CODE_W-1:0] code);
        logic ok;
        case (code)
            NOTE_NONE, NOTE_R, NOTE_G, NOTE_B, NOTE_Y, NOTE_RG, NOTE_BY,
            NOTE_RG2, NOTE_YB2, NOTE_ALT0, NOTE_ALT1, NOTE_ALT2, NOTE_ALT3:
                ok = 1'b1;
            default:
                ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/chart_sequencer_frame_delay_counter.sv
// -----------------------------------------------------------------------------
// frame_delay_counter
// 10-bit frame countdown used while a chart entry waits out its delay.
//   clk, rst     : clock, asynchronous active-high reset
//   clear_i      : force the count to zero (highest priority)
//   load_i       : load load_val_i
//   load_val_i   : countdown start value
//   tick_i       : decrement by one (no effect at zero)
//   zero_o       : count is zero
//   expire_o     : this tick takes the count from 1 to 0
// -----------------------------------------------------------------------------
module frame_delay_counter
    import chart_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear_i,
    input  logic               load_i,
    input  logic [DELAY_W-1:0] load_val_i,
    input  logic               tick_i,
    output logic               zero_o,
    output logic               expire_o
);

    logic [DELAY_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - DELAY_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o   = (count_q == '0);
    // Flagged on the tick itself so the owner can advance without an idle cycle.
    assign expire_o = tick_i && (count_q == DELAY_W'(1));

endmodule

// File: rtl/chart_sequencer.sv
// -----------------------------------------------------------------------------
// chart_sequencer
// Walks the note chart ROM: fetches an entry at pc, pulses note_valid with
// the entry's lane code (if nonzero), then waits the entry's frame delay
// before advancing. A delay equal to END_DELAY ends the chart; running past
// LAST_PC also ends it without wrapping.
//
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : begin the chart at address 0 (from IDLE or DONE)
//   stop          : synchronous abort to IDLE, priority over start
//   frame_tick    : one pulse per video frame
//   pause         : freezes delay countdown and frame counting
//   rom_data      : {code[3:0], delay[9:0]} at pc, combinational ROM
//   pc            : ROM address
//   note_valid    : one-cycle note spawn pulse
//   note_code     : lane code, valid with note_valid (zero otherwise)
//   busy          : chart in progress (FETCH/EMIT/WAIT)
//   done          : chart finished (DONE state)
//   frame_count   : frames seen while busy since start, saturating
//
// Build option: SEQ_PAUSE_EN enables the pause input; without it pause is
// ignored and should be tied 0.
// -----------------------------------------------------------------------------
module chart_sequencer
    import chart_pkg::*;
#(
    parameter int unsigned PC_W      = 8,
    parameter int unsigned LAST_PC   = 156,
    parameter int unsigned END_DELAY = chart_pkg::END_DELAY
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               frame_tick,
    input  logic               pause,
    input  logic [ENTRY_W-1:0] rom_data,
    output logic [PC_W-1:0]    pc,
    output logic               note_valid,
    output logic [CODE_W-1:0]  note_code,
    output logic               busy,
    output logic               done,
    output logic [15:0]        frame_count
);

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [15:0]        fcnt_q, fcnt_d;

    logic tick_en;
    logic busy_w;
    logic advance;
    logic cnt_load, cnt_clear, cnt_zero, cnt_expire;

`ifdef SEQ_PAUSE_EN
    assign tick_en = frame_tick && !pause;
`else
    assign tick_en = frame_tick;
    logic unused_pause;
    assign unused_pause = pause;
`endif

    assign busy_w = (state_q == ST_FETCH) || (state_q == ST_EMIT) || (state_q == ST_WAIT);

    frame_delay_counter u_delay (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .load_val_i (delay_q),
        .tick_i     (tick_en && (state_q == ST_WAIT)),
        .zero_o     (cnt_zero),
        .expire_o   (cnt_expire)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        code_d    = code_q;
        delay_d   = delay_q;
        fcnt_d    = fcnt_q;
        cnt_load  = 1'b0;
        cnt_clear = 1'b0;
        advance   = 1'b0;

        if (busy_w && tick_en && (fcnt_q != '1)) begin
            fcnt_d = fcnt_q + 16'd1;
        end

        if (stop) begin
            state_d   = ST_IDLE;
            pc_d      = '0;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d = ST_FETCH;
                        pc_d    = '0;
                        fcnt_d  = '0;
                    end
                end
                ST_FETCH: begin
                    code_d  = rom_data[ENTRY_W-1:DELAY_W];
                    delay_d = rom_data[DELAY_W-1:0];
                    state_d = ST_EMIT;
                end
                ST_EMIT: begin
                    if (delay_q == DELAY_W'(END_DELAY)) begin
                        state_d = ST_DONE;
                    end else if (delay_q == '0) begin
                        advance = 1'b1;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // cnt_zero only guards against a stuck WAIT; loads are never zero.
                    if (cnt_expire || cnt_zero) begin
                        advance = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (advance) begin
                if (pc_q == PC_W'(LAST_PC)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            code_q  <= '0;
            delay_q <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
            delay_q <= delay_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Pulse is decoded from EMIT so it lands in the same cycle; a coincident
    // stop cancels it.
    assign note_valid  = (state_q == ST_EMIT) && (code_q != '0) && !stop;
    assign note_code   = note_valid ? code_q : '0;
    assign pc          = pc_q;
    assign busy        = busy_w;
    assign done        = (state_q == ST_DONE);
    assign frame_count = fcnt_q;

endmodule

// File: tb/tb_chart_sequencer.sv
// -----------------------------------------------------------------------------
// tb_chart_sequencer
// Directed bench for chart_sequencer: reset values, a short chart with an end
// marker, running off the last ROM address, stop/restart, asynchronous reset
// mid-wait, and pause handling (behaviour depends on SEQ_PAUSE_EN).
// -----------------------------------------------------------------------------
module tb_chart_sequencer;
    import chart_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic        frame_tick;
    logic        pause;
    logic [13:0] rom_data;
    logic [7:0]  pc;
    logic        note_valid;
    logic [3:0]  note_code;
    logic        busy;
    logic        done;
    logic [15:0] frame_count;

    logic [13:0] rom [256];

    int checks = 0;
    int errors = 0;

`ifdef SEQ_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    assign rom_data = rom[pc];

    chart_sequencer #(
        .PC_W      (8),
        .LAST_PC   (156),
        .END_DELAY (1000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .rom_data    (rom_data),
        .pc          (pc),
        .note_valid  (note_valid),
        .note_code   (note_code),
        .busy        (busy),
        .done        (done),
        .frame_count (frame_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: tick applied to this edge, pulses dropped after it,
    // outputs sampled 1 ns later by the caller.
    task automatic cycle(input logic tick);
        frame_tick = tick;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
    endtask

    function automatic logic [13:0] ent(input logic [3:0] c, input int unsigned d);
        logic [31:0] dv;
        dv = d;
        return {c, dv[9:0]};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    initial begin
        int          npulse;
        int          pk [4];
        logic [3:0]  pcode [4];
        logic [7:0]  maxpc;
        bit          got;
        int          nt;

        rst = 1'b1; start = 1'b0; stop = 1'b0; frame_tick = 1'b0; pause = 1'b0;
        clear_rom();

        // ---------------- reset values ----------------
        #1;
        check("rst_pc", pc, 0);
        check("rst_note_valid", note_valid, 0);
        check("rst_note_code", note_code, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_frame_count", frame_count, 0);
        cycle(0);
        cycle(0);
        rst = 1'b0;
        cycle(0);
        check("idle_busy", busy, 0);

        // ---------------- short chart, tick every 10 cycles ----------------
        rom[0] = ent(NOTE_NONE, 2);
        rom[1] = ent(NOTE_R, 0);
        rom[2] = ent(NOTE_B, 1);
        rom[3] = ent(NOTE_RG2, 1000);
        start = 1'b1;
        cycle(0);
        check("t1_busy_after_start", busy, 1);
        check("t1_pc_start", pc, 0);
        npulse = 0;
        for (int k = 0; k < 40; k++) begin
            cycle((k % 10) == 9);
            if (note_valid) begin
                if (npulse < 4) begin
                    pk[npulse]    = k;
                    pcode[npulse] = note_code;
                end
                npulse++;
                check("t1_code_defined", code_is_defined(note_code), 1);
            end
            if (k == 31) begin
                check("t1_done", done, 1);
                check("t1_busy_done", busy, 0);
                check("t1_pc_end", pc, 3);
            end
        end
        check("t1_pulse_count", npulse, 3);
        if (npulse >= 3) begin
            check("t1_code0", pcode[0], NOTE_R);
            check("t1_code1", pcode[1], NOTE_B);
            check("t1_code2", pcode[2], NOTE_RG2);
            check("t1_first_after_tick2", pk[0], 20);
            check("t1_zero_delay_gap", ((pk[1] - pk[0]) == 2) || ((pk[1] - pk[0]) == 3), 1);
            check("t1_last_after_tick3", pk[2], 30);
        end
        check("t1_frame_count", frame_count, 3);

        // ---------------- run off LAST_PC ----------------
        for (int i = 0; i < 256; i++) rom[i] = ent(NOTE_NONE, 0);
        start = 1'b1;
        cycle(0);
        maxpc = '0;
        got   = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            cycle(0);
            if (pc > maxpc) maxpc = pc;
            if (done) got = 1'b1;
        end
        check("t2_done_reached", got, 1);
        check("t2_pc_last", pc, 156);
        check("t2_busy", busy, 0);
        check("t2_max_pc", maxpc, 156);
        repeat (5) cycle(0);
        check("t2_pc_held", pc, 156);
        check("t2_done_held", done, 1);

        // ---------------- stop during WAIT, then replay ----------------
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = ent(4'(i + 1), 0);
        rom[5] = ent(NOTE_BY, 3);
        rom[6] = ent(NOTE_YB2, 1000);
        start = 1'b1;
        cycle(0);
        check("t3_restart_pc", pc, 0);
        check("t3_restart_busy", busy, 1);
        check("t3_restart_done", done, 0);
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle(0);
            if (note_valid && (note_code == NOTE_BY)) got = 1'b1;
        end
        check("t3_reached_pc5", got, 1);
        cycle(0);
        cycle(1);
        check("t3_pc_wait", pc, 5);
        check("t3_busy_wait", busy, 1);
        stop = 1'b1;
        cycle(0);
        check("t3_stop_pc", pc, 0);
        check("t3_stop_busy", busy, 0);
        check("t3_stop_done", done, 0);
        check("t3_stop_nv", note_valid, 0);
        start = 1'b1;
        cycle(0);
        cycle(0);
        check("t3_replay_nv", note_valid, 1);
        check("t3_replay_code", note_code, 1);
        cycle(0);
        cycle(0);
        check("t3_entry1_code", note_code, 2);
        cycle(0);
        cycle(0);
        stop = 1'b1;
        #1;
        check("t3_stop_emit_nv", note_valid, 0);
        check("t3_stop_emit_code", note_code, 0);
        cycle(0);
        check("t3_stop_emit_pc", pc, 0);
        check("t3_stop_emit_busy", busy, 0);

        // ---------------- asynchronous reset mid-WAIT ----------------
        clear_rom();
        rom[0] = ent(NOTE_R, 5);
        start = 1'b1;
        cycle(0);
        cycle(0);
        cycle(1);
        check("t4_fc_emit_tick", frame_count, 1);
        cycle(1);
        check("t4_fc_wait_tick", frame_count, 2);
        check("t4_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t4_rst_pc", pc, 0);
        check("t4_rst_nv", note_valid, 0);
        check("t4_rst_code", note_code, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_done", done, 0);
        check("t4_rst_fc", frame_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(0);
        check("t4_idle_after_rst", busy, 0);
        start = 1'b1;
        stop  = 1'b1;
        cycle(0);
        check("t4_stop_over_start", busy, 0);

        // ---------------- pause ----------------
        clear_rom();
        rom[0] = ent(NOTE_G, 4);
        rom[1] = ent(NOTE_Y, 1000);
        start = 1'b1;
        cycle(0);
        cycle(0);
        check("t5_first_code", note_code, NOTE_G);
        cycle(1);
        check("t5_fc_emit", frame_count, 1);
        pause = 1'b1;
        repeat (3) begin
            cycle(1);
            cycle(0);
        end
        check("t5_fc_paused", frame_count, PAUSE_ON ? 1 : 4);
        check("t5_busy_paused", busy, 1);
        pause = 1'b0;
        got = 1'b0;
        nt  = 0;
        for (int t = 0; t < 8 && !got; t++) begin
            cycle(1);
            nt++;
            cycle(0);
            if (note_valid) got = 1'b1;
        end
        check("t5_note_seen", got, 1);
        check("t5_unpaused_ticks", nt, PAUSE_ON ? 4 : 1);
        check("t5_second_code", note_code, NOTE_Y);
        check("t5_fc_final", frame_count, 5);
        cycle(0);
        check("t5_done", done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
